// File: rtl/fft_out_stream.sv
// Drain stage after the last FFT butterfly: reads one ping-pong half of the real/imag
// result buffers and streams N complex samples on a valid/ready port under ap_ctrl_chain.
module fft_out_stream #(
   parameter int N       = 1024,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int SHIFT   = 0,
   parameter int BIT_REV = 0
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   output logic              ap_done,
   input  logic              ap_continue,
   output logic              ap_idle,
   output logic              ap_ready,
   output logic [ADDR_W-1:0] X_R_address0,
   output logic              X_R_ce0,
   input  logic [DATA_W-1:0] X_R_q0,
   output logic [ADDR_W-1:0] X_I_address0,
   output logic              X_I_ce0,
   input  logic [DATA_W-1:0] X_I_q0,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_last
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t state, state_nxt;

   logic                        ap_done_reg;
   logic [ADDR_W:0]             rd_idx;
   logic                        inflight;
   logic                        inflight_last;
   logic [1:0][DATA_W-1:0]      fifo_re;
   logic [1:0][DATA_W-1:0]      fifo_im;
   logic [1:0]                  fifo_last;
   logic                        wr_ptr;
   logic                        rd_ptr;
   logic [1:0]                  fifo_count;

   logic                        start_acc;
   logic                        pop;
   logic                        done_pulse;
   logic                        issue;
   logic [2:0]                  slots_used;
   logic [ADDR_W-1:0]           rev_idx;
   logic [ADDR_W-1:0]           rd_addr;
   logic signed [DATA_W-1:0]    re_sh;
   logic signed [DATA_W-1:0]    im_sh;

   // Output port: a beat transfers on a cycle where out_valid & out_ready; while
   // out_valid is high and out_ready low the payload is held unchanged.
   assign out_valid = (fifo_count != 2'd0);
   assign out_re    = fifo_re[rd_ptr];
   assign out_im    = fifo_im[rd_ptr];
   assign out_last  = fifo_last[rd_ptr];

   assign start_acc  = (state == S_IDLE) && ap_start && !ap_done_reg;
   assign pop        = out_valid && out_ready;
   assign done_pulse = (state == S_RUN) && pop && out_last;

   // Slots committed after this cycle's pop; crediting the pop keeps one read per cycle
   // while still bounding reads-ahead to the two FIFO entries.
   assign slots_used = 3'(fifo_count) + 3'(inflight) - 3'(pop);
   assign issue      = (state == S_RUN) && (rd_idx < (ADDR_W+1)'(N)) && (slots_used < 3'd2);

   always_comb begin
      rev_idx = '0;
      for (int b = 0; b < ADDR_W; b++) begin
         rev_idx[b] = rd_idx[ADDR_W-1-b];
      end
   end

   assign rd_addr      = (BIT_REV != 0) ? rev_idx : rd_idx[ADDR_W-1:0];
   assign X_R_address0 = rd_addr;
   assign X_I_address0 = rd_addr;
   assign X_R_ce0      = issue;
   assign X_I_ce0      = issue;

   assign re_sh = $signed(X_R_q0) >>> SHIFT;
   assign im_sh = $signed(X_I_q0) >>> SHIFT;

   always_comb begin
      state_nxt = state;
      ap_done   = done_pulse | ap_done_reg;
      ap_ready  = done_pulse;
      ap_idle   = (state == S_IDLE) && !ap_start;
      case (state)
         S_IDLE: if (start_acc)  state_nxt = S_RUN;
         S_RUN:  if (done_pulse) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state         <= S_IDLE;
         ap_done_reg   <= 1'b0;
         rd_idx        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_re       <= '0;
         fifo_im       <= '0;
         fifo_last     <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         fifo_count    <= 2'd0;
      end else begin
         state <= state_nxt;

         if (done_pulse && !ap_continue) begin
            ap_done_reg <= 1'b1;
         end else if (ap_continue) begin
            ap_done_reg <= 1'b0;
         end

         if (start_acc) begin
            rd_idx <= '0;
         end else if (issue) begin
            rd_idx <= rd_idx + 1'b1;
         end

         // Buffer read data arrives one cycle after ce0; tag travels alongside it.
         inflight      <= issue;
         inflight_last <= issue && (rd_idx == (ADDR_W+1)'(N-1));

         if (inflight) begin
            fifo_re[wr_ptr]   <= re_sh;
            fifo_im[wr_ptr]   <= im_sh;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end

         case ({inflight, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_out_stream.sv
// Bench for fft_out_stream: three instances (natural, bit-reversed, shift-by-2) run in
// lockstep against buffer models; a scoreboard checks every beat and every read issue.
module tb_fft_out_stream;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int DW = 32;
   localparam int NI = 3;

   // ---------------- clock / reset ----------------
   logic ap_clk      = 1'b0;
   logic ap_rst_n    = 1'b0;
   logic ap_start    = 1'b0;
   logic ap_continue = 1'b1;
   logic out_ready   = 1'b1;

   always #5 ap_clk = ~ap_clk;

   logic          ap_done   [NI];
   logic          ap_idle   [NI];
   logic          ap_ready  [NI];
   logic [AW-1:0] xr_addr   [NI];
   logic [AW-1:0] xi_addr   [NI];
   logic          xr_ce     [NI];
   logic          xi_ce     [NI];
   logic [DW-1:0] xr_q      [NI];
   logic [DW-1:0] xi_q      [NI];
   logic          out_valid [NI];
   logic [DW-1:0] out_re    [NI];
   logic [DW-1:0] out_im    [NI];
   logic          out_last  [NI];

   logic [DW-1:0] mem_r [NI][N];
   logic [DW-1:0] mem_i [NI][N];

   fft_out_stream #(.N(N), .ADDR_W(AW), .DATA_W(DW), .SHIFT(0), .BIT_REV(0)) u_nat (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done[0]),
      .ap_continue(ap_continue), .ap_idle(ap_idle[0]), .ap_ready(ap_ready[0]),
      .X_R_address0(xr_addr[0]), .X_R_ce0(xr_ce[0]), .X_R_q0(xr_q[0]),
      .X_I_address0(xi_addr[0]), .X_I_ce0(xi_ce[0]), .X_I_q0(xi_q[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_re(out_re[0]),
      .out_im(out_im[0]), .out_last(out_last[0]));

   fft_out_stream #(.N(N), .ADDR_W(AW), .DATA_W(DW), .SHIFT(0), .BIT_REV(1)) u_rev (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done[1]),
      .ap_continue(ap_continue), .ap_idle(ap_idle[1]), .ap_ready(ap_ready[1]),
      .X_R_address0(xr_addr[1]), .X_R_ce0(xr_ce[1]), .X_R_q0(xr_q[1]),
      .X_I_address0(xi_addr[1]), .X_I_ce0(xi_ce[1]), .X_I_q0(xi_q[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_re(out_re[1]),
      .out_im(out_im[1]), .out_last(out_last[1]));

   fft_out_stream #(.N(N), .ADDR_W(AW), .DATA_W(DW), .SHIFT(2), .BIT_REV(0)) u_shift (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done[2]),
      .ap_continue(ap_continue), .ap_idle(ap_idle[2]), .ap_ready(ap_ready[2]),
      .X_R_address0(xr_addr[2]), .X_R_ce0(xr_ce[2]), .X_R_q0(xr_q[2]),
      .X_I_address0(xi_addr[2]), .X_I_ce0(xi_ce[2]), .X_I_q0(xi_q[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready), .out_re(out_re[2]),
      .out_im(out_im[2]), .out_last(out_last[2]));

   // Result buffers: registered read, data valid the cycle after ce0.
   always @(posedge ap_clk) begin
      for (int i = 0; i < NI; i++) begin
         if (xr_ce[i]) xr_q[i] <= mem_r[i][xr_addr[i]];
         if (xi_ce[i]) xi_q[i] <= mem_i[i][xi_addr[i]];
      end
   end

   // ---------------- model and scoreboard ----------------
   int            checks   = 0;
   int            failures = 0;
   logic [64:0]   exp_q [NI][$];
   int            rd_k     [NI];
   int            issued   [NI];
   int            accepted [NI];
   logic          stall    [NI];
   logic [64:0]   held     [NI];
   logic [DW-1:0] seen_re  [NI][N];
   logic [DW-1:0] seen_im  [NI][N];
   int            rev_lit  [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
   logic          toggle_mode = 1'b0;

   function automatic void check(string name, logic [95:0] act, logic [95:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic int rev3(int j);
      return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
   endfunction

   function automatic int model_addr(int i, int k);
      return (i == 1) ? rev3(k) : k;
   endfunction

   function automatic logic [64:0] exp_beat(int i, int j);
      logic signed [DW-1:0] r;
      logic signed [DW-1:0] m;
      int a;
      int sh;
      a  = model_addr(i, j);
      sh = (i == 2) ? 2 : 0;
      r  = $signed(mem_r[i][a]);
      m  = $signed(mem_i[i][a]);
      r  = r >>> sh;
      m  = m >>> sh;
      return {(j == N-1), r, m};
   endfunction

   initial begin
      logic [64:0] cur;
      logic [64:0] e;
      forever begin
         @(negedge ap_clk);
         for (int i = 0; i < NI; i++) begin
            if (!ap_rst_n) begin
               check("rst_outputs", {out_valid[i], xr_ce[i], ap_done[i]}, 3'b000);
               exp_q[i].delete();
               rd_k[i]     = 0;
               issued[i]   = 0;
               accepted[i] = 0;
               stall[i]    = 1'b0;
            end else begin
               check("imag_port_match", {xi_ce[i], xi_addr[i]}, {xr_ce[i], xr_addr[i]});
               if (xr_ce[i]) begin
                  check("rd_in_range", rd_k[i] < N, 1);
                  check("rd_addr", xr_addr[i], model_addr(i, rd_k[i]));
                  rd_k[i]++;
                  issued[i]++;
               end
               cur = {out_last[i], out_re[i], out_im[i]};
               if (stall[i]) check("stall_hold", {out_valid[i], cur}, {1'b1, held[i]});
               stall[i] = 1'b0;
               if (out_valid[i]) begin
                  if (out_ready) begin
                     if (exp_q[i].size() == 0) begin
                        check("extra_beat", cur, 0);
                     end else begin
                        e = exp_q[i].pop_front();
                        check("beat", cur, e);
                     end
                     seen_re[i][accepted[i] % N] = out_re[i];
                     seen_im[i][accepted[i] % N] = out_im[i];
                     accepted[i]++;
                  end else begin
                     stall[i] = 1'b1;
                     held[i]  = cur;
                  end
               end
               check("reads_ahead", (issued[i] - accepted[i]) > 2, 0);
            end
         end
      end
   end

   // Backpressure pattern 1,0,0,1 repeating while enabled.
   initial begin
      logic [3:0] pat;
      int rc;
      pat = 4'b1001;
      rc  = 0;
      forever begin
         @(posedge ap_clk);
         #1;
         if (toggle_mode) begin
            out_ready = pat[rc % 4];
            rc++;
         end else begin
            rc = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_frame();
      ap_start = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      for (int i = 0; i < NI; i++) begin
         rd_k[i] = 0;
         for (int j = 0; j < N; j++) exp_q[i].push_back(exp_beat(i, j));
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (cyc < 200) begin
         @(negedge ap_clk);
         if (ap_done[0]) break;
         cyc++;
      end
      if (cyc >= 200) begin
         check("done_timeout", 0, 1);
      end else begin
         for (int i = 0; i < NI; i++)
            check("done_cycle", {ap_done[i], ap_ready[i], out_last[i], out_valid[i], out_ready},
                  5'b11111);
      end
      @(posedge ap_clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      logic [DW-1:0] v;

      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < N; k++) begin
            mem_r[i][k] = (i == 2) ? DW'(-9) : DW'(k);
            mem_i[i][k] = (i == 2) ? DW'(9)  : DW'(-k);
         end
      end

      repeat (2) @(negedge ap_clk);
      check("rst_idle_done_ready", {ap_idle[0], ap_done[0], ap_ready[0]}, 3'b100);
      check("rst_stream", {out_valid[0], xr_ce[0], out_last[0], out_re[0], out_im[0]}, 0);
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Frame A: full throughput.
      start_frame();
      wait_done(cyc);
      check("latency_a", cyc, 9);
      @(posedge ap_clk);
      #1;
      for (int j = 0; j < N; j++) begin
         v = DW'(j);
         check("nat_re", seen_re[0][j], v);
         v = DW'(-j);
         check("nat_im", seen_im[0][j], v);
         v = DW'(rev_lit[j]);
         check("rev_re", seen_re[1][j], v);
         v = DW'(-rev_lit[j]);
         check("rev_im", seen_im[1][j], v);
         v = DW'(-3);
         check("shift_re", seen_re[2][j], v);
         v = DW'(2);
         check("shift_im", seen_im[2][j], v);
      end
      check("idle_after_a", ap_idle[0], 1'b1);

      // Frame B: backpressure.
      toggle_mode = 1'b1;
      start_frame();
      wait_done(cyc);
      toggle_mode = 1'b0;
      out_ready   = 1'b1;
      @(negedge ap_clk);
      for (int i = 0; i < NI; i++) check("drain_b", exp_q[i].size(), 0);

      // Frame C: ap_done held without ap_continue; start ignored meanwhile.
      @(posedge ap_clk);
      #1;
      ap_continue = 1'b0;
      start_frame();
      wait_done(cyc);
      check("latency_c", cyc, 9);
      ap_start = 1'b1;
      repeat (3) begin
         @(negedge ap_clk);
         for (int i = 0; i < NI; i++)
            check("held_done", {ap_done[i], ap_idle[i], out_valid[i], xr_ce[i]}, 4'b1000);
      end
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      @(negedge ap_clk);
      check("held_done_idle", {ap_done[0], ap_idle[0], ap_ready[0]}, 3'b110);
      ap_continue = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      check("continue_clears", ap_done[0], 1'b0);
      start_frame();
      wait_done(cyc);
      check("latency_c2", cyc, 9);

      // Frame D: async reset at beat 3, then full replay.
      start_frame();
      cyc = 0;
      while (accepted[0] < 3 && cyc < 50) begin
         @(negedge ap_clk);
         cyc++;
      end
      check("reach_beat3", accepted[0] >= 3, 1);
      #2;
      ap_rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++)
         check("async_rst_drop", {out_valid[i], xr_ce[i], ap_done[i]}, 3'b000);
      @(negedge ap_clk);
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      start_frame();
      wait_done(cyc);
      check("latency_d", cyc, 9);

      repeat (3) @(negedge ap_clk);
      for (int i = 0; i < NI; i++) check("drain_end", exp_q[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
